mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Sequences the multi-cycle multiply/divide unit in stage E of the five-stage MIPS pipeline and owns the architectural HI/LO registers.
- Accepts one operation per start pulse, computes the result, holds it for a fixed latency with busy high, then commits it to HI/LO.
- The hazard/stall logic stalls D-stage md/mt/mf instructions on (busy | start).
- A macroscopic exception request (req) cancels any operation launched in the same cycle.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (and madd-family when enabled); legal range 1..15.
- DIV_LAT, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage md/mt instruction valid this cycle.
- mdu_op  input  4  operation code (package constants).
- rs_data  input  32  forwarded GPR[rs].
- rt_data  input  32  forwarded GPR[rt].
- req  input  1  exception/interrupt flush; kills a start in the same cycle.
- busy  output  1  operation in flight.
- hi  output  32  committed HI.
- lo  output  32  committed LO.
- done  output  1  one-cycle pulse in the cycle after HI/LO commit.

Behaviour:
- Reset (asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, pending result=0.
- FSM has two states, IDLE and BUSY.
- IDLE, start&!req, op MULT/MULTU/DIV/DIVU:
  - Capture {hi,lo} result into the pending registers from rs_data/rt_data.
  - Load counter with MULT_LAT or DIV_LAT.
  - Go to BUSY.
- IDLE, start&!req, op MTHI/MTLO:
  - hi<=rs_data or lo<=rs_data at that edge; busy stays 0.
- IDLE, start&req: ignored entirely; no state, HI/LO or counter change.
- MDU_NONE and undefined opcodes with start: ignored.
- BUSY:
  - counter decrements each edge.
  - At the edge where counter==1: hi/lo<=pending, state->IDLE, done=1 for the next cycle.
  - busy is high exactly LAT cycles, starting the cycle after the start edge.
  - New HI/LO values are visible in the first cycle with busy=0.
- req while BUSY: no effect; the in-flight instruction has already passed E and is architecturally committed.
- start while BUSY: ignored; the stall logic guarantees this cannot occur.
- Arithmetic:
  - MULT: signed 32x32->64, {hi,lo}=product.
  - MULTU: unsigned 32x32->64, {hi,lo}=product.
  - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (rt_data==0): full DIV_LAT busy period runs; HI/LO left unchanged at commit.
- No combinational path from any input to busy/hi/lo/done; all outputs are registered.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds MADD, MADDU, MSUB and MSUBU.
  - {hi,lo} <= {hi,lo} ± product, 64-bit wrap-around, signed or unsigned product per op.
  - Uses MULT_LAT.
  - Accumulator operand is the committed {hi,lo} sampled at the start edge.
- Undefined: those opcodes are treated as undefined and ignored.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - FSM state constants IDLE/BUSY.
  - Default latency constants.
- One combinational sub-module, mdu_calc: takes op, rs, rt and current {hi,lo}; produces the 64-bit result plus a write-enable (0 for divide-by-zero). It keeps the arithmetic separate from sequencing.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3: busy high cycles 1..5; cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1.
- DIVU rs=100, rt=7: busy high 10 cycles, then lo=14, hi=2.
- DIV rs=-7 (0xFFFFFFF9), rt=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=5, rt=0 after MTHI 0x1234 and MTLO 0x5678: busy high 10 cycles; then hi=0x1234, lo=0x5678.
- MULT with start&req in the same cycle: busy stays 0 and hi/lo unchanged. Separately, req pulsed mid-BUSY: commit still occurs on schedule.
- reset asserted in cycle 3 of a DIV: busy, hi, lo and done are 0 immediately (asynchronously); a following MTLO 0xA5A5A5A5 gives lo=0xA5A5A5A5 on the next edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - opcodes, FSM states and latency defaults for the MDU (optional MDU_MADD_EN)
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Opcodes that occupy the unit for a multi-cycle busy period.
  function automatic logic mdu_is_long(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Divides use the longer latency; everything else long uses the multiply latency.
  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - E-stage pipeline to MDU request/result bundle
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  modport master (
    output start, mdu_op, rs_data, rt_data, req,
    input  busy, hi, lo, done
  );

  modport slave (
    input  start, mdu_op, rs_data, rt_data, req,
    output busy, hi, lo, done
  );
endinterface

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational multiply/divide arithmetic (accumulate ops under MDU_MADD_EN)
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [63:0] acc,
  output logic [63:0] result,
  output logic        we
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] rt_safe;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] q_m;
  logic [31:0] r_m;
  logic [31:0] q_s;
  logic [31:0] r_s;

`ifndef MDU_MADD_EN
  logic unused_acc;
  assign unused_acc = ^acc;
`endif

  // Products and quotients; signed divide runs on magnitudes so the
  // 0x80000000 / -1 case falls out naturally and a zero divisor never reaches the divider.
  always_comb begin
    prod_s  = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u  = {32'd0, rs} * {32'd0, rt};
    rt_safe = (rt == 32'd0) ? 32'd1 : rt;
    q_u     = rs / rt_safe;
    r_u     = rs % rt_safe;
    rs_mag  = rs[31] ? (32'd0 - rs) : rs;
    rt_mag  = rt[31] ? (32'd0 - rt) : rt_safe;
    q_m     = rs_mag / rt_mag;
    r_m     = rs_mag % rt_mag;
    q_s     = (rs[31] ^ rt[31]) ? (32'd0 - q_m) : q_m;
    r_s     = rs[31] ? (32'd0 - r_m) : r_m;
  end

  // Select the 64-bit {hi,lo} result; divide by zero suppresses the write.
  always_comb begin
    result = 64'd0;
    we     = 1'b0;
    case (op)
      MDU_MULT:  begin result = prod_s;     we = 1'b1; end
      MDU_MULTU: begin result = prod_u;     we = 1'b1; end
      MDU_DIV:   begin result = {r_s, q_s}; we = (rt != 32'd0); end
      MDU_DIVU:  begin result = {r_u, q_u}; we = (rt != 32'd0); end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin result = acc + prod_s; we = 1'b1; end
      MDU_MADDU: begin result = acc + prod_u; we = 1'b1; end
      MDU_MSUB:  begin result = acc - prod_s; we = 1'b1; end
      MDU_MSUBU: begin result = acc - prod_u; we = 1'b1; end
`endif
      default:   begin result = 64'd0; we = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU sequencer owning HI/LO (accumulate ops under MDU_MADD_EN)
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic      clk,
  input  logic      reset,
  mdu_ctrl_if.slave mdu
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  mdu_state_t  state_q;
  mdu_state_t  state_d;
  logic [3:0]  cnt_q;
  logic [63:0] pend_q;
  logic        pend_we_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        accept;
  logic        launch;
  logic        commit;
  logic        mthi_we;
  logic        mtlo_we;
  logic [63:0] calc_result;
  logic        calc_we;

  // The accumulator operand is the committed {hi,lo} as seen at the start edge.
  mdu_calc u_calc (
    .op     (mdu.mdu_op),
    .rs     (mdu.rs_data),
    .rt     (mdu.rt_data),
    .acc    ({hi_q, lo_q}),
    .result (calc_result),
    .we     (calc_we)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave IDLE on a launched long op, return on the commit edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = BUSY;
      BUSY:    if (commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM decode: a start with req in the same cycle is dropped, as is any start while BUSY.
  always_comb begin
    accept  = mdu.start & ~mdu.req;
    launch  = 1'b0;
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        launch  = accept & mdu_is_long(mdu.mdu_op);
        mthi_we = accept & (mdu.mdu_op == MDU_MTHI);
        mtlo_we = accept & (mdu.mdu_op == MDU_MTLO);
      end
      BUSY:    commit = (cnt_q == 4'd1);
      default: ;
    endcase
  end

  // Capture the result and latency at launch, then count down while BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      pend_q    <= 64'd0;
      pend_we_q <= 1'b0;
    end else if (launch) begin
      cnt_q     <= mdu_is_div(mdu.mdu_op) ? DIV_CNT : MULT_CNT;
      pend_q    <= calc_result;
      pend_we_q <= calc_we;
    end else if (state_q == BUSY) begin
      cnt_q     <= cnt_q - 4'd1;
    end
  end

  // Architectural HI/LO: committed result or direct moves from rs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (commit) begin
      if (pend_we_q) begin
        hi_q <= pend_q[63:32];
        lo_q <= pend_q[31:0];
      end
    end else begin
      if (mthi_we) hi_q <= mdu.rs_data;
      if (mtlo_we) lo_q <= mdu.rs_data;
    end
  end

  // Done pulses in the first cycle after the commit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= commit;
  end

  assign mdu.busy = (state_q == BUSY);
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;
  assign mdu.done = done_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed-vector bench for mdu_ctrl
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  mdu_ctrl_if bus ();

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mdu_op  = op;
    bus.rs_data = a;
    bus.rt_data = b;
    bus.req     = r;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.req    = 1'b0;
    bus.mdu_op = MDU_NONE;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int req_at, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(op, a, b, 1'b0);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      bus.req = (n == req_at);
      @(negedge clk);
    end
    bus.req = 1'b0;
    check({tag, ".lat"}, 32'(n), 32'(lat));
    check({tag, ".hi"}, bus.hi, exp_hi);
    check({tag, ".lo"}, bus.lo, exp_lo);
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    @(negedge clk);
    check({tag, ".done_clr"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.mdu_op  = MDU_NONE;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    bus.req     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.hi", bus.hi, 32'd0);
    check("rst.lo", bus.lo, 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    reset = 1'b0;

    run_op("mult_neg", MDU_MULT, 32'hFFFFFFFE, 32'd3, -1, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7, -1, 10, 32'd2, 32'd14);
    run_op("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, -1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negd", MDU_DIV, 32'd7, 32'hFFFFFFFE, -1, 10, 32'd1, 32'hFFFFFFFD);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 10, 32'd0, 32'h80000000);
    run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 5, 32'hFFFFFFFE, 32'd1);
    run_op("mult_min", MDU_MULT, 32'h80000000, 32'h80000000, -1, 5, 32'h40000000, 32'd0);

    issue(MDU_MTHI, 32'h1234, 32'd0, 1'b0);
    check("mthi.busy", 32'(bus.busy), 32'd0);
    check("mthi.hi", bus.hi, 32'h1234);
    issue(MDU_MTLO, 32'h5678, 32'd0, 1'b0);
    check("mtlo.lo", bus.lo, 32'h5678);
    check("mtlo.hi", bus.hi, 32'h1234);
    run_op("div0", MDU_DIV, 32'd5, 32'd0, -1, 10, 32'h1234, 32'h5678);

    issue(MDU_MULT, 32'd6, 32'd7, 1'b1);
    check("kill.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("kill.busy2", 32'(bus.busy), 32'd0);
    check("kill.hi", bus.hi, 32'h1234);
    check("kill.lo", bus.lo, 32'h5678);
    issue(MDU_MTHI, 32'hBEEF, 32'd0, 1'b1);
    check("kill_mthi.hi", bus.hi, 32'h1234);

    issue(4'd11, 32'd9, 32'd9, 1'b0);
    check("undef.busy", 32'(bus.busy), 32'd0);
    check("undef.lo", bus.lo, 32'h5678);
    issue(MDU_NONE, 32'd9, 32'd9, 1'b0);
    check("none.busy", 32'(bus.busy), 32'd0);
    check("none.hi", bus.hi, 32'h1234);

`ifdef MDU_MADD_EN
    issue(MDU_MTHI, 32'd0, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'd10, 32'd0, 1'b0);
    run_op("madd", MDU_MADD, 32'd3, 32'd4, -1, 5, 32'd0, 32'd22);
    run_op("msub", MDU_MSUB, 32'd5, 32'd5, -1, 5, 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
    issue(MDU_MADD, 32'd3, 32'd4, 1'b0);
    check("madd_off.busy", 32'(bus.busy), 32'd0);
    check("madd_off.hi", bus.hi, 32'h1234);
    check("madd_off.lo", bus.lo, 32'h5678);
`endif

    run_op("req_mid", MDU_MULT, 32'd6, 32'd7, 2, 5, 32'd0, 32'd42);

    issue(MDU_MTHI, 32'h77, 32'd0, 1'b0);
    issue(MDU_DIV, 32'd100, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    check("rstmid.busy_pre", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rstmid.busy", 32'(bus.busy), 32'd0);
    check("rstmid.hi", bus.hi, 32'd0);
    check("rstmid.lo", bus.lo, 32'd0);
    check("rstmid.done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(MDU_MTLO, 32'hA5A5A5A5, 32'd0, 1'b0);
    check("post_rst.lo", bus.lo, 32'hA5A5A5A5);
    check("post_rst.busy", 32'(bus.busy), 32'd0);
    check("post_rst.hi", bus.hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
